// File: rtl/pmt_gate_scheduler_if.sv
// Readout side of the PMT gate scheduler: two hold banks (A/B), each with its
// own valid/ack handshake. The scheduler drives the master modport.
interface pmt_gate_scheduler_if #(
    parameter int CNT_W = 16
) ();
    logic [CNT_W-1:0] count_a;
    logic [CNT_W-1:0] count_b;
    logic             valid_a;
    logic             valid_b;
    logic             ack_a;
    logic             ack_b;

    modport master (
        output count_a,
        output count_b,
        output valid_a,
        output valid_b,
        input  ack_a,
        input  ack_b
    );

    modport slave (
        input  count_a,
        input  count_b,
        input  valid_a,
        input  valid_b,
        output ack_a,
        output ack_b
    );
endinterface

// File: rtl/pmt_gate_scheduler.sv
// Timed PMT counting gate: runs programmed windows and ping-pongs counts into banks A/B.
// Define PMT_SYNC_EN to synchronise pmt_in (2 flops + rising-edge detect, 3-cycle latency).
module pmt_gate_scheduler #(
    parameter int CNT_W = 16,
    parameter int LEN_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] gate_len,
    input  logic [LEN_W-1:0] dead_len,
    input  logic [7:0]       n_windows,
    input  logic             pmt_in,
    pmt_gate_scheduler_if.master rd,
    output logic             gate,
    output logic             bank_sel,
    output logic             overrun,
    output logic             sat,
    output logic             busy,
    output logic [7:0]       win_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [LEN_W-1:0] gate_len_sh;
    logic [LEN_W-1:0] dead_len_sh;
    logic [7:0]       n_win_sh;
    logic [LEN_W-1:0] len_cnt;
    logic [CNT_W-1:0] evt_cnt;
    logic [CNT_W-1:0] count_a_q;
    logic [CNT_W-1:0] count_b_q;
    logic             valid_a_q;
    logic             valid_b_q;
    logic             evt;
    logic             last_win;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // True when this increment pins the counter at full scale.
    function automatic logic sat_hit(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX - 1'b1);
    endfunction

`ifdef PMT_SYNC_EN
    logic sync_p0;
    logic sync_p1;
    logic hist_p2;
    logic evt_p2;

    // Stage p0/p1: metastability flops; stage p2: edge history and registered pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            hist_p2 <= 1'b0;
            evt_p2  <= 1'b0;
        end else begin
            sync_p0 <= pmt_in;
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;
            evt_p2  <= sync_p1 & ~hist_p2;
        end
    end

    assign evt = evt_p2;
`else
    assign evt = pmt_in;
`endif

    assign last_win = (n_win_sh != 8'd0) && ((win_idx + 8'd1) == n_win_sh);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            gate        <= 1'b0;
            busy        <= 1'b0;
            bank_sel    <= 1'b0;
            overrun     <= 1'b0;
            sat         <= 1'b0;
            win_idx     <= '0;
            len_cnt     <= '0;
            evt_cnt     <= '0;
            gate_len_sh <= LEN_W'(1);
            dead_len_sh <= '0;
            n_win_sh    <= '0;
            count_a_q   <= '0;
            count_b_q   <= '0;
            valid_a_q   <= 1'b0;
            valid_b_q   <= 1'b0;
        end else begin
            // Acks clear valids; a latch below to the same bank overrides the clear.
            if (rd.ack_a) valid_a_q <= 1'b0;
            if (rd.ack_b) valid_b_q <= 1'b0;

            if (abort && (state != IDLE)) begin
                state   <= IDLE;
                gate    <= 1'b0;
                busy    <= 1'b0;
                evt_cnt <= '0;
                len_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            gate_len_sh <= (gate_len == '0) ? LEN_W'(1) : gate_len;
                            dead_len_sh <= dead_len;
                            n_win_sh    <= n_windows;
                            win_idx     <= '0;
                            evt_cnt     <= '0;
                            len_cnt     <= '0;
                            overrun     <= 1'b0;
                            sat         <= 1'b0;
                            state       <= GATE;
                            gate        <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end

                    GATE: begin
                        if (evt) begin
                            evt_cnt <= sat_inc(evt_cnt);
                            if (sat_hit(evt_cnt)) sat <= 1'b1;
                        end
                        if (len_cnt == gate_len_sh - 1'b1) begin
                            len_cnt <= '0;
                            state   <= LATCH;
                            gate    <= 1'b0;
                        end else begin
                            len_cnt <= len_cnt + 1'b1;
                        end
                    end

                    LATCH: begin
                        if (!bank_sel) begin
                            count_a_q <= evt_cnt;
                            valid_a_q <= 1'b1;
                            if (valid_a_q && !rd.ack_a) overrun <= 1'b1;
                        end else begin
                            count_b_q <= evt_cnt;
                            valid_b_q <= 1'b1;
                            if (valid_b_q && !rd.ack_b) overrun <= 1'b1;
                        end
                        bank_sel <= ~bank_sel;
                        evt_cnt  <= '0;
                        win_idx  <= win_idx + 8'd1;
                        if (last_win) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (dead_len_sh != '0) begin
                            state <= DEAD;
                        end else begin
                            state <= GATE;
                            gate  <= 1'b1;
                        end
                    end

                    DEAD: begin
                        if (len_cnt == dead_len_sh - 1'b1) begin
                            len_cnt <= '0;
                            state   <= GATE;
                            gate    <= 1'b1;
                        end else begin
                            len_cnt <= len_cnt + 1'b1;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        gate  <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rd.count_a = count_a_q;
    assign rd.count_b = count_b_q;
    assign rd.valid_a = valid_a_q;
    assign rd.valid_b = valid_b_q;

endmodule

// File: tb/tb_pmt_gate_scheduler.sv
// Bench for pmt_gate_scheduler: table of single-window runs checked through a
// scoreboard, then directed multi-window, saturation, overrun, abort and reset sequences.
module tb_pmt_gate_scheduler;
    localparam int CNT_W = 16;
    localparam int LEN_W = 16;

`ifdef PMT_SYNC_EN
    localparam int E_W1 = 1, E_W2 = 1, E_SAT16 = 1, E_SAT4 = 1, E_SATF = 0;
    localparam int E_OV1 = 1, E_OV3 = 1, E_AB1 = 0, E_AB2 = 0;
`else
    localparam int E_W1 = 4, E_W2 = 7, E_SAT16 = 20, E_SAT4 = 15, E_SATF = 1;
    localparam int E_OV1 = 1, E_OV3 = 3, E_AB1 = 1, E_AB2 = 2;
`endif

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             pmt_in = 1'b0;
    logic [LEN_W-1:0] gate_len = '0;
    logic [LEN_W-1:0] dead_len = '0;
    logic [7:0]       n_windows = '0;
    logic             gate, bank_sel, overrun, sat, busy;
    logic [7:0]       win_idx;
    logic             gate4, bank_sel4, overrun4, sat4, busy4;
    logic [7:0]       win_idx4;

    pmt_gate_scheduler_if #(.CNT_W(CNT_W)) rd ();
    pmt_gate_scheduler_if #(.CNT_W(4))     rd4 ();

    assign rd4.ack_a = rd.ack_a;
    assign rd4.ack_b = rd.ack_b;

    pmt_gate_scheduler #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .gate_len(gate_len), .dead_len(dead_len), .n_windows(n_windows),
        .pmt_in(pmt_in), .rd(rd), .gate(gate), .bank_sel(bank_sel),
        .overrun(overrun), .sat(sat), .busy(busy), .win_idx(win_idx)
    );

    pmt_gate_scheduler #(.CNT_W(4), .LEN_W(LEN_W)) dut4 (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .gate_len(gate_len), .dead_len(dead_len), .n_windows(n_windows),
        .pmt_in(pmt_in), .rd(rd4), .gate(gate4), .bank_sel(bank_sel4),
        .overrun(overrun4), .sat(sat4), .busy(busy4), .win_idx(win_idx4)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] glen;
        logic [19:0] mask;
        logic [15:0] exp_raw;
        logic [15:0] exp_sync;
    } vec_t;

    typedef struct {
        logic             bank;
        logic [CNT_W-1:0] cnt;
    } sb_t;

    vec_t vecs [11];
    sb_t  sbq [$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   sb_en = 1'b0;
    logic exp_bank = 1'b0;
    logic va_prev = 1'b0;
    logic vb_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input logic bank, input logic [CNT_W-1:0] cnt);
        sb_t e;
        if (sbq.size() == 0) begin
            chk("sb_underflow", 32'(sbq.size()), 32'd1);
        end else begin
            e = sbq.pop_front();
            chk("sb_bank", 32'(bank), 32'(e.bank));
            chk("sb_count", 32'(cnt), 32'(e.cnt));
        end
    endtask

    always @(negedge clock) begin
        if (sb_en && rd.valid_a && !va_prev) sb_pop(1'b0, rd.count_a);
        if (sb_en && rd.valid_b && !vb_prev) sb_pop(1'b1, rd.count_b);
        va_prev = rd.valid_a;
        vb_prev = rd.valid_b;
    end

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        pmt_in   = 1'b0;
        rd.ack_a = 1'b0;
        rd.ack_b = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        next();
    endtask

    // Pulses start for one cycle; returns in the first gate cycle.
    task automatic do_start(input logic [15:0] gl, input logic [15:0] dl, input logic [7:0] nw);
        gate_len  = gl;
        dead_len  = dl;
        n_windows = nw;
        start     = 1'b1;
        next();
        start     = 1'b0;
    endtask

    task automatic run_vec(input int k);
        logic [15:0] e;
        e = vecs[k].exp_raw;
`ifdef PMT_SYNC_EN
        e = vecs[k].exp_sync;
`endif
        sbq.push_back('{exp_bank, e});
        exp_bank = ~exp_bank;
        do_start(vecs[k].glen, 16'd0, 8'd1);
        for (int i = 0; i < 20; i++) begin
            pmt_in = vecs[k].mask[i];
            next();
        end
        pmt_in = 1'b0;
        @(negedge clock);
        chk("vec_win_idx", 32'(win_idx), 32'd1);
        chk("vec_busy", 32'(busy), 32'd0);
        rd.ack_a = 1'b1;
        rd.ack_b = 1'b1;
        next();
        rd.ack_a = 1'b0;
        rd.ack_b = 1'b0;
    endtask

    initial begin
        int r1, r2, fall;
        logic gp, bp;

        vecs[0]  = '{16'd5,  20'h00000, 16'd0,  16'd0};
        vecs[1]  = '{16'd5,  20'hFFFFF, 16'd5,  16'd1};
        vecs[2]  = '{16'd0,  20'h00001, 16'd1,  16'd0};
        vecs[3]  = '{16'd0,  20'hFFFFE, 16'd0,  16'd0};
        vecs[4]  = '{16'd8,  20'h000AA, 16'd4,  16'd2};
        vecs[5]  = '{16'd16, 20'hFFFFF, 16'd16, 16'd1};
        vecs[6]  = '{16'd3,  20'h00008, 16'd0,  16'd0};
        vecs[7]  = '{16'd3,  20'h00004, 16'd1,  16'd0};
        vecs[8]  = '{16'd10, 20'h002AA, 16'd5,  16'd3};
        vecs[9]  = '{16'd10, 20'h001F0, 16'd5,  16'd1};
        vecs[10] = '{16'd10, 20'hFFF00, 16'd2,  16'd0};

        do_reset();
        @(negedge clock);
        chk("rst_gate", 32'(gate), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid_a", 32'(rd.valid_a), 32'd0);
        chk("rst_valid_b", 32'(rd.valid_b), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_bank_sel", 32'(bank_sel), 32'd0);
        chk("rst_count_a", 32'(rd.count_a), 32'd0);
        chk("rst_count_b", 32'(rd.count_b), 32'd0);
        chk("rst_win_idx", 32'(win_idx), 32'd0);
        next();

        sb_en = 1'b1;
        for (int k = 0; k < 11; k++) run_vec(k);
        sb_en = 1'b0;
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        // Two windows, period L+D+1 = 13
        do_reset();
        r1 = -1; r2 = -1; fall = -1; gp = 1'b0; bp = 1'b1;
        do_start(16'd10, 16'd2, 8'd2);
        for (int c = 1; c <= 30; c++) begin
            pmt_in = ((c >= 2) && (c <= 5)) || ((c >= 15) && (c <= 21));
            @(negedge clock);
            if (gate && !gp) begin
                if (r1 < 0) r1 = c;
                else if (r2 < 0) r2 = c;
            end
            if (!busy && bp && (fall < 0)) fall = c;
            gp = gate;
            bp = busy;
            next();
        end
        pmt_in = 1'b0;
        chk("w2_first_rise", r1, 1);
        chk("w2_period", r2 - r1, 13);
        chk("w2_busy_fall", fall, 25);
        chk("w2_count_a", 32'(rd.count_a), E_W1);
        chk("w2_count_b", 32'(rd.count_b), E_W2);
        chk("w2_win_idx", 32'(win_idx), 32'd2);
        chk("w2_valid_a", 32'(rd.valid_a), 32'd1);
        chk("w2_valid_b", 32'(rd.valid_b), 32'd1);
        chk("w2_overrun", 32'(overrun), 32'd0);

        // Saturation: 4-bit counter clips at 15
        do_reset();
        do_start(16'd20, 16'd0, 8'd1);
        for (int c = 1; c <= 24; c++) begin
            pmt_in = (c <= 22);
            next();
        end
        pmt_in = 1'b0;
        @(negedge clock);
        chk("sat_count16", 32'(rd.count_a), E_SAT16);
        chk("sat_sat16", 32'(sat), 32'd0);
        chk("sat_count4", 32'(rd4.count_a), E_SAT4);
        chk("sat_sat4", 32'(sat4), E_SATF);
        next();

        // Continuous run, no acks: third latch overruns bank A
        do_reset();
        do_start(16'd4, 16'd1, 8'd0);
        for (int c = 1; c <= 18; c++) begin
            pmt_in = (c == 1) || ((c >= 13) && (c <= 15));
            @(negedge clock);
            if (c == 12) begin
                chk("ovr_none_yet", 32'(overrun), 32'd0);
                chk("ovr_count_a1", 32'(rd.count_a), E_OV1);
                chk("ovr_valid_b", 32'(rd.valid_b), 32'd1);
            end
            if (c == 18) begin
                chk("ovr_set", 32'(overrun), 32'd1);
                chk("ovr_count_a3", 32'(rd.count_a), E_OV3);
                chk("ovr_count_b", 32'(rd.count_b), 32'd0);
                chk("ovr_valid_a", 32'(rd.valid_a), 32'd1);
                chk("ovr_bank_sel", 32'(bank_sel), 32'd1);
                chk("ovr_win_idx", 32'(win_idx), 32'd3);
            end
            next();
        end
        pmt_in = 1'b0;
        abort = 1'b1;
        next();
        abort = 1'b0;
        @(negedge clock);
        chk("ovr_abort_idle", 32'(busy), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        do_start(16'd4, 16'd1, 8'd1);
        @(negedge clock);
        chk("ovr_clr_on_start", 32'(overrun), 32'd0);
        chk("ovr_restart_gate", 32'(gate), 32'd1);
        chk("ovr_restart_idx", 32'(win_idx), 32'd0);
        abort = 1'b1;
        next();
        abort = 1'b0;

        // Ack in the latch cycle suppresses overrun; ack_b clears valid_b; abort stops latching
        do_reset();
        do_start(16'd4, 16'd1, 8'd0);
        for (int c = 1; c <= 25; c++) begin
            pmt_in   = (c == 1) || ((c >= 13) && (c <= 15));
            rd.ack_a = (c == 17);
            rd.ack_b = (c == 19);
            abort    = (c == 21);
            @(negedge clock);
            if (c == 18) begin
                chk("ack_latch_overrun", 32'(overrun), 32'd0);
                chk("ack_latch_valid_a", 32'(rd.valid_a), 32'd1);
                chk("ack_latch_count_a", 32'(rd.count_a), E_OV3);
            end
            if (c == 20) chk("ack_b_clears", 32'(rd.valid_b), 32'd0);
            if (c == 22) begin
                chk("abort_gate_busy", 32'(busy), 32'd0);
                chk("abort_gate_gate", 32'(gate), 32'd0);
            end
            if (c == 25) begin
                chk("abort_no_latch", 32'(rd.valid_b), 32'd0);
                chk("abort_win_idx", 32'(win_idx), 32'd3);
                chk("abort_bank_sel", 32'(bank_sel), 32'd1);
            end
            next();
        end
        pmt_in = 1'b0; rd.ack_a = 1'b0; rd.ack_b = 1'b0; abort = 1'b0;

        // Abort in the dead time before window 3; start mid-run ignored
        do_reset();
        do_start(16'd3, 16'd3, 8'd0);
        for (int c = 1; c <= 18; c++) begin
            pmt_in   = (c == 2) || (c == 8) || (c == 9);
            start    = (c == 9);
            gate_len = (c == 9) ? 16'd7 : 16'd3;
            abort    = (c == 13);
            @(negedge clock);
            if (c == 10) chk("ign_gate_hi", 32'(gate), 32'd1);
            if (c == 11) chk("ign_gate_len", 32'(gate), 32'd0);
            if (c == 12) chk("ign_win_idx", 32'(win_idx), 32'd2);
            if (c == 14) begin
                chk("dead_abort_busy", 32'(busy), 32'd0);
                chk("dead_abort_idx", 32'(win_idx), 32'd2);
            end
            if (c == 18) begin
                chk("dead_abort_cnt_a", 32'(rd.count_a), E_AB1);
                chk("dead_abort_cnt_b", 32'(rd.count_b), E_AB2);
                chk("dead_abort_va", 32'(rd.valid_a), 32'd1);
                chk("dead_abort_vb", 32'(rd.valid_b), 32'd1);
                chk("dead_abort_bsel", 32'(bank_sel), 32'd0);
            end
            next();
        end
        pmt_in = 1'b0; start = 1'b0; abort = 1'b0;

        // Asynchronous reset mid-gate
        do_start(16'd10, 16'd0, 8'd1);
        pmt_in = 1'b1;
        repeat (4) next();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_gate", 32'(gate), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid_a", 32'(rd.valid_a), 32'd0);
        chk("arst_valid_b", 32'(rd.valid_b), 32'd0);
        chk("arst_count_b", 32'(rd.count_b), 32'd0);
        chk("arst_win_idx", 32'(win_idx), 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (15) next();
        @(negedge clock);
        chk("arst_no_latch", 32'(rd.valid_a), 32'd0);
        chk("arst_idle", 32'(busy), 32'd0);
        pmt_in = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
